// File: rtl/dec_scan_ctrl_if.sv
// Control/status bundle between a scan requester and dec_scan_ctrl.
// The slave side drives the decoder select code, enable and status flags.
interface dec_scan_ctrl_if;
    logic       start;
    logic       stop;
    logic [3:0] mask;
    logic [1:0] Din;
    logic       en;
    logic       busy;
    logic       wrap;

    modport master (output start, stop, mask, input  Din, en, busy, wrap);
    modport slave  (input  start, stop, mask, output Din, en, busy, wrap);
endinterface

// File: rtl/dec_scan_ctrl.sv
// Scans a 2:4 decoder through the mask-enabled codes: BLANK cycles en low, then DWELL cycles en high.
// All outputs are registered; stop and rst return to idle on the next edge.
module dec_scan_ctrl #(
    parameter int DWELL = 8,
    parameter int BLANK = 2,
    parameter int CW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    dec_scan_ctrl_if.slave  ctl
);
    typedef enum logic [1:0] {S_IDLE, S_GAP, S_HOLD} state_t;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam state_t        CODE_ST    = (BLANK == 0) ? S_HOLD : S_GAP;
    localparam logic          CODE_EN    = (BLANK == 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    din_q, din_d;
    logic          en_q, en_d;
    logic          busy_q, busy_d;
    logic          wrap_q, wrap_d;

    logic          gap_done;
    logic          dwell_done;
    logic          mask_any;
    logic [1:0]    first_idx;
    logic [1:0]    next_idx;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Circular search above cur; wraps back onto cur itself for a single-bit mask.
    function automatic logic [1:0] next_set(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] idx;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && m[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign mask_any   = |ctl.mask;
    assign first_idx  = lowest_set(ctl.mask);
    assign next_idx   = next_set(din_q, ctl.mask);
    assign gap_done   = (state_q == S_GAP)  && (cnt_q == BLANK_LAST);
    assign dwell_done = (state_q == S_HOLD) && (cnt_q == DWELL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            din_q   <= 2'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ctl.stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (ctl.start && mask_any) state_d = CODE_ST;
                S_GAP:   if (gap_done) state_d = S_HOLD;
                S_HOLD:  if (dwell_done) state_d = mask_any ? CODE_ST : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        din_d  = din_q;
        en_d   = en_q;
        busy_d = busy_q;
        wrap_d = 1'b0;
        if (ctl.stop) begin
            cnt_d  = '0;
            din_d  = 2'd0;
            en_d   = 1'b0;
            busy_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctl.start && mask_any) begin
                        cnt_d  = '0;
                        din_d  = first_idx;
                        en_d   = CODE_EN;
                        busy_d = 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_done) begin
                        cnt_d = '0;
                        en_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (dwell_done) begin
                        cnt_d = '0;
                        if (!mask_any) begin
                            din_d  = 2'd0;
                            en_d   = 1'b0;
                            busy_d = 1'b0;
                        end else begin
                            din_d  = next_idx;
                            en_d   = CODE_EN;
                            wrap_d = (next_idx <= din_q);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_d  = '0;
                    din_d  = 2'd0;
                    en_d   = 1'b0;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    assign ctl.Din  = din_q;
    assign ctl.en   = en_q;
    assign ctl.busy = busy_q;
    assign ctl.wrap = wrap_q;
endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Bench for dec_scan_ctrl with DWELL=4, BLANK=2: directed scenarios followed by random traffic,
// every cycle compared against a period-position reference model.
module tb_dec_scan_ctrl;
    localparam int DWELL  = 4;
    localparam int BLANK  = 2;
    localparam int PERIOD = DWELL + BLANK;

    logic clk;
    logic rst;
    dec_scan_ctrl_if ifc ();

    dec_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK), .CW(16)) dut (
        .clk (clk),
        .rst (rst),
        .ctl (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int wraps_seen = 0;

    // Reference: a scan is a sequence of periods; pos counts cycles within the current period.
    bit       m_busy = 1'b0;
    int       m_code = 0;
    int       m_pos  = 0;
    bit       m_wrap = 1'b0;

    function automatic int lowest_bit(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_bit(input int cur, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) if (m[(cur + k) % 4]) return (cur + k) % 4;
        return cur;
    endfunction

    task automatic model_step();
        int nxt;
        m_wrap = 1'b0;
        if (rst || ifc.stop) begin
            m_busy = 1'b0; m_code = 0; m_pos = 0;
        end else if (!m_busy) begin
            if (ifc.start && ifc.mask != 4'b0) begin
                m_busy = 1'b1; m_code = lowest_bit(ifc.mask); m_pos = 0;
            end
        end else if (m_pos == PERIOD - 1) begin
            m_pos = 0;
            if (ifc.mask == 4'b0) begin
                m_busy = 1'b0; m_code = 0;
            end else begin
                nxt    = next_bit(m_code, ifc.mask);
                m_wrap = (nxt <= m_code);
                m_code = nxt;
            end
        end else begin
            m_pos++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("din",  32'(ifc.Din),  32'(m_code));
        check("en",   32'(ifc.en),   32'(m_busy && (m_pos >= BLANK)));
        check("busy", 32'(ifc.busy), 32'(m_busy));
        check("wrap", 32'(ifc.wrap), 32'(m_wrap));
        if (ifc.wrap === 1'b1) wraps_seen++;
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start(input logic [3:0] m);
        ifc.mask  = m;
        ifc.start = 1'b1;
        step();
    endtask

    task automatic pulse_stop();
        ifc.stop = 1'b1;
        step();
    endtask

    initial begin
        rst       = 1'b1;
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
        ifc.mask  = 4'b0;

        // Reset and quiescent idle.
        @(posedge clk); #1; rst = 1'b1;
        step_keep_rst();
        run(4);
        check("idle_busy", 32'(ifc.busy), 32'd0);

        // Full mask: one wrap per 24-cycle round, at 3->0.
        pulse_start(4'b1111);
        wraps_seen = 0;
        run(25);
        check("wrap_cnt_1111", 32'(wraps_seen), 32'd1);
        pulse_stop();

        // Alternating mask 1010.
        pulse_start(4'b1010);
        wraps_seen = 0;
        run(30);
        check("wrap_cnt_1010", 32'(wraps_seen), 32'd2);
        pulse_stop();

        // Single bit: wraps every period; then clear mask mid-HOLD.
        pulse_start(4'b0100);
        wraps_seen = 0;
        run(18);
        check("wrap_cnt_0100", 32'(wraps_seen), 32'd3);
        ifc.mask = 4'b0000;
        run(6);
        check("idle_after_clear", 32'(ifc.busy), 32'd0);

        // Stop in second HOLD cycle.
        pulse_start(4'b1111);
        run(3);
        pulse_stop();
        check("stop_en", 32'(ifc.en), 32'd0);
        // start and stop together: stop wins.
        ifc.start = 1'b1; ifc.stop = 1'b1;
        step();
        check("start_stop_busy", 32'(ifc.busy), 32'd0);
        // start with empty mask ignored.
        pulse_start(4'b0000);
        run(2);
        check("empty_start_busy", 32'(ifc.busy), 32'd0);

        // Reset in the middle of code 2 HOLD, then restart.
        pulse_start(4'b1111);
        run(15);
        check("pre_rst_din", 32'(ifc.Din), 32'd2);
        rst = 1'b1;
        step();
        run(1);
        pulse_start(4'b1111);
        run(8);
        pulse_stop();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) ifc.mask = 4'($urandom_range(0, 15));
            ifc.start = ($urandom_range(0, 7)   == 0);
            ifc.stop  = ($urandom_range(0, 59)  == 0);
            rst       = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Holds rst for a second cycle before releasing it via the normal step.
    task automatic step_keep_rst();
        rst = 1'b1;
        step();
    endtask
endmodule
